// File: rtl/watch_timekeeper_if.sv
// Control and display bundle between the button front-end, the timekeeper core
// and the display multiplexer.
interface watch_timekeeper_if;
    logic [1:0] mode;
    logic       plus_pulse;
    logic       minus_pulse;
    logic       fmt_toggle;
    logic [7:0] secs;
    logic [7:0] mins;
    logic [7:0] hours;
    logic       pm;
    logic       fmt24;
    logic       tick_1hz;

    modport master (
        output mode, plus_pulse, minus_pulse, fmt_toggle,
        input  secs, mins, hours, pm, fmt24, tick_1hz
    );

    modport slave (
        input  mode, plus_pulse, minus_pulse, fmt_toggle,
        output secs, mins, hours, pm, fmt24, tick_1hz
    );
endinterface

// File: rtl/watch_timekeeper.sv
// Time-of-day core: prescaled 1 Hz seconds/minutes/hours with set modes and 12/24 h display.
// Define WATCH_TK_BCD_EN for packed-BCD outputs; binary outputs otherwise.
module watch_timekeeper #(
    parameter int CLK_HZ     = 50_000_000,
    parameter bit FMT24_INIT = 1'b1,
    parameter int RESET_HOUR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    watch_timekeeper_if.slave     bus
);
    localparam int            PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    localparam logic [1:0] MODE_RUN = 2'b00;
    localparam logic [1:0] MODE_SEC = 2'b01;
    localparam logic [1:0] MODE_MIN = 2'b10;
    localparam logic [1:0] MODE_HR  = 2'b11;

    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hr;
    logic          r_fmt24;
    logic          r_tick;
    logic [1:0]    r_mode_prev;

    logic          w_wrap;
    logic          w_sec_entry;
    logic          w_inc;
    logic          w_dec;
    logic [4:0]    w_hr12;

    function automatic logic [7:0] to_out(input logic [5:0] v);
`ifdef WATCH_TK_BCD_EN
        int t;
        int o;
        t = int'(v) / 10;
        o = int'(v) % 10;
        return {4'(t), 4'(o)};
`else
        return {2'b00, v};
`endif
    endfunction

    assign w_wrap      = (r_presc == PRESC_MAX);
    assign w_sec_entry = (bus.mode == MODE_SEC) && (r_mode_prev != MODE_SEC);
    assign w_inc       = bus.plus_pulse & ~bus.minus_pulse;
    assign w_dec       = bus.minus_pulse & ~bus.plus_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc     <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_hr        <= 5'(RESET_HOUR);
            r_fmt24     <= FMT24_INIT;
            r_tick      <= 1'b0;
            r_mode_prev <= MODE_RUN;
        end else begin
            r_mode_prev <= bus.mode;
            r_tick      <= 1'b0;
            if (bus.fmt_toggle) r_fmt24 <= ~r_fmt24;

            if (bus.mode == MODE_RUN) begin
                if (w_wrap) begin
                    r_presc <= '0;
                    r_tick  <= 1'b1;
                    if (r_sec == 6'd59) begin
                        r_sec <= '0;
                        if (r_min == 6'd59) begin
                            r_min <= '0;
                            r_hr  <= (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
                        end else begin
                            r_min <= r_min + 6'd1;
                        end
                    end else begin
                        r_sec <= r_sec + 6'd1;
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end else begin
                // Time is frozen in set modes; the phase restarts on return to run.
                r_presc <= '0;
                if (w_sec_entry) begin
                    r_sec <= '0;
                end else if (w_inc || w_dec) begin
                    unique case (bus.mode)
                        MODE_SEC: r_sec <= w_inc ? ((r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1)
                                                 : ((r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1);
                        MODE_MIN: r_min <= w_inc ? ((r_min == 6'd59) ? 6'd0 : r_min + 6'd1)
                                                 : ((r_min == 6'd0) ? 6'd59 : r_min - 6'd1);
                        MODE_HR:  r_hr  <= w_inc ? ((r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1)
                                                 : ((r_hr == 5'd0) ? 5'd23 : r_hr - 5'd1);
                        default:  ;
                    endcase
                end
            end
        end
    end

    // 12 h decode: midnight and noon both read 12.
    assign w_hr12 = (r_hr == 5'd0) ? 5'd12 : ((r_hr > 5'd12) ? r_hr - 5'd12 : r_hr);

    assign bus.secs     = to_out(r_sec);
    assign bus.mins     = to_out(r_min);
    assign bus.hours    = to_out({1'b0, (r_fmt24 ? r_hr : w_hr12)});
    assign bus.pm       = (r_hr >= 5'd12);
    assign bus.fmt24    = r_fmt24;
    assign bus.tick_1hz = r_tick;
endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper at CLK_HZ=10.
module tb_watch_timekeeper;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    watch_timekeeper_if bus();

    watch_timekeeper #(.CLK_HZ(10), .FMT24_INIT(1'b1), .RESET_HOUR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp8(input int v);
`ifdef WATCH_TK_BCD_EN
        return {4'(v / 10), 4'(v % 10)};
`else
        return 8'(v);
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input bit plus, input bit minus, input bit tog);
        bus.plus_pulse  = plus;
        bus.minus_pulse = minus;
        bus.fmt_toggle  = tog;
        step(1);
        bus.plus_pulse  = 1'b0;
        bus.minus_pulse = 1'b0;
        bus.fmt_toggle  = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset           = 1'b1;
        bus.mode        = 2'b00;
        bus.plus_pulse  = 1'b0;
        bus.minus_pulse = 1'b0;
        bus.fmt_toggle  = 1'b0;

        step(1);
        chk("rst_secs",  bus.secs,  exp8(0));
        chk("rst_mins",  bus.mins,  exp8(0));
        chk("rst_hours", bus.hours, exp8(0));
        chk("rst_pm",    8'(bus.pm),       8'd0);
        chk("rst_fmt24", 8'(bus.fmt24),    8'd1);
        chk("rst_tick",  8'(bus.tick_1hz), 8'd0);

        reset = 1'b0;
        step(9);
        chk("run_tick_early", 8'(bus.tick_1hz), 8'd0);
        chk("run_secs_early", bus.secs, exp8(0));
        step(1);
        chk("run_tick1", 8'(bus.tick_1hz), 8'd1);
        chk("run_secs1", bus.secs, exp8(1));
        step(1);
        chk("run_tick_drop", 8'(bus.tick_1hz), 8'd0);
        step(9);
        chk("run_tick2", 8'(bus.tick_1hz), 8'd1);
        chk("run_secs2", bus.secs, exp8(2));

        // Preset 23:59:59
        bus.mode = 2'b11;
        pulse(1'b0, 1'b1, 1'b0);
        chk("set_hr_wrap_dn", bus.hours, exp8(23));
        chk("set_no_tick", 8'(bus.tick_1hz), 8'd0);
        bus.mode = 2'b10;
        pulse(1'b0, 1'b1, 1'b0);
        chk("set_min_wrap_dn", bus.mins, exp8(59));
        chk("set_min_hr_kept", bus.hours, exp8(23));
        pulse(1'b1, 1'b1, 1'b0);
        chk("set_both_nochg", bus.mins, exp8(59));
        bus.mode = 2'b01;
        pulse(1'b1, 1'b0, 1'b0);
        chk("sec_entry_clear", bus.secs, exp8(0));
        pulse(1'b0, 1'b1, 1'b0);
        chk("set_sec_wrap_dn", bus.secs, exp8(59));
        chk("set_pm_23", 8'(bus.pm), 8'd1);

        // Day rollover
        bus.mode = 2'b00;
        step(9);
        chk("roll_secs_hold", bus.secs, exp8(59));
        chk("roll_tick_early", 8'(bus.tick_1hz), 8'd0);
        step(1);
        chk("roll_secs",  bus.secs,  exp8(0));
        chk("roll_mins",  bus.mins,  exp8(0));
        chk("roll_hours", bus.hours, exp8(0));
        chk("roll_pm",    8'(bus.pm), 8'd0);
        chk("roll_tick",  8'(bus.tick_1hz), 8'd1);
        step(1);
        chk("roll_tick_single", 8'(bus.tick_1hz), 8'd0);

        // Seconds-entry clear from 37
        bus.mode = 2'b01;
        step(1);
        for (int i = 0; i < 23; i++) pulse(1'b0, 1'b1, 1'b0);
        chk("set_sec_37", bus.secs, exp8(37));
        bus.mode = 2'b10;
        step(1);
        bus.mode = 2'b01;
        pulse(1'b1, 1'b0, 1'b0);
        chk("sec_entry_37", bus.secs, exp8(0));
        pulse(1'b1, 1'b0, 1'b0);
        chk("sec_inc_after", bus.secs, exp8(1));

        // 12/24 h format
        bus.mode = 2'b11;
        pulse(1'b0, 1'b0, 1'b1);
        chk("fmt12_flag", 8'(bus.fmt24), 8'd0);
        chk("fmt12_midnight", bus.hours, exp8(12));
        chk("fmt12_pm0", 8'(bus.pm), 8'd0);
        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0, 1'b0);
        chk("fmt12_noon", bus.hours, exp8(12));
        chk("fmt12_noon_pm", 8'(bus.pm), 8'd1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("fmt12_13", bus.hours, exp8(1));
        chk("fmt12_13_pm", 8'(bus.pm), 8'd1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("fmt24_13", bus.hours, exp8(13));
        chk("fmt24_flag", 8'(bus.fmt24), 8'd1);

        // Reset mid-count
        bus.mode = 2'b00;
        step(6);
        reset = 1'b1;
        step(1);
        chk("mrst_secs",  bus.secs,  exp8(0));
        chk("mrst_mins",  bus.mins,  exp8(0));
        chk("mrst_hours", bus.hours, exp8(0));
        chk("mrst_pm",    8'(bus.pm), 8'd0);
        chk("mrst_tick",  8'(bus.tick_1hz), 8'd0);
        reset = 1'b0;
        step(9);
        chk("mrst_tick_early", 8'(bus.tick_1hz), 8'd0);
        step(1);
        chk("mrst_tick", 8'(bus.tick_1hz), 8'd1);
        chk("mrst_secs1", bus.secs, exp8(1));

        // 45 seconds decode
        bus.mode = 2'b01;
        step(1);
        for (int i = 0; i < 45; i++) pulse(1'b1, 1'b0, 1'b0);
        chk("secs_45", bus.secs, exp8(45));
        chk("mins_0",  bus.mins, exp8(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/watch_timekeeper.md
# watch_timekeeper

Parametrised time-of-day core for the watch project. Generalises the fixed 50 MHz seconds/minutes/hours counter with a configurable input clock rate, a synchronous reset, a frozen-time set mode, a 12/24-hour display format, and a 1 Hz strobe for downstream blocks such as alarm and stopwatch. It sits between the button debouncer/pulse generator and the display multiplexer.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency; prescaler divides by this value, minimum 2.
- FMT24_INIT, 1, display format after reset: 1 = 24 h, 0 = 12 h.
- RESET_HOUR, 0, internal hour value (0..23) loaded at reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears/loads all state on the next clk edge.
- mode  in  2  00 run, 01 set seconds, 10 set minutes, 11 set hours.
- plus_pulse  in  1  one-cycle increment request for the selected field.
- minus_pulse  in  1  one-cycle decrement request for the selected field.
- fmt_toggle  in  1  one-cycle request to toggle the 12/24 h format.
- secs  out  8  seconds 0..59.
- mins  out  8  minutes 0..59.
- hours  out  8  hours, 0..23 in 24 h format, 1..12 in 12 h format.
- pm  out  1  1 when internal hour >= 12, valid in both formats.
- fmt24  out  1  current format: 1 = 24 h.
- tick_1hz  out  1  one-cycle strobe on each run-mode second boundary.

## Operation
- State: prescaler of width $clog2(CLK_HZ), sec_r 0..59, min_r 0..59, hr_r 0..23, fmt24_r.
- Reset: prescaler=0, sec_r=0, min_r=0, hr_r=RESET_HOUR, fmt24_r=FMT24_INIT, tick_1hz=0. Reset overrides all other inputs.
- Run mode (00):
  - Prescaler counts 0..CLK_HZ-1 and wraps.
  - A wrap is a tick: tick_1hz=1 for that cycle and sec_r advances.
  - sec_r 59->0 carries into min_r. Minute 59->0 with a seconds carry carries into hr_r. Hour 23->0.
  - Both plus_pulse and minus_pulse are ignored.
- Set modes (01/10/11):
  - Prescaler is held at 0, no ticks are produced, and time is frozen.
  - plus_pulse alone increments the selected field modulo its range (59->0, 23->0).
  - minus_pulse alone decrements it (0->59, 0->23).
  - There is no carry or borrow into other fields.
  - plus_pulse and minus_pulse in the same cycle cause no change.
  - Entering set seconds (01) from any other mode clears sec_r to 0 on the first cycle in that mode. A pulse arriving in that same cycle is ignored.
- Leaving set mode for run: prescaler restarts from 0, so the first tick occurs CLK_HZ cycles after the first run-mode cycle.
- Mode changes between set modes take effect the same cycle. A pulse applies to the field selected by mode in that cycle.
- fmt_toggle inverts fmt24_r in any mode. It affects only the hours and fmt24 outputs.
- Hour decode for 12 h format: hr_r 0 -> 12 with pm=0; 1..11 -> 1..11; 12 -> 12 with pm=1; 13..23 -> 1..11.
- Outputs secs, mins, hours and pm are combinational decodes of the state registers. No extra latency beyond the state update.

## Timing
- Input pulses are sampled on the clk edge and the field is updated on that same edge; visible the following cycle.
- tick_1hz is registered and asserted in the cycle after the prescaler holds CLK_HZ-1. The time registers update on that same edge.
- The full-day rollover 23:59:59 -> 00:00:00 happens on a single clk edge.
- Reset asserted mid-count discards the prescaler phase. After deassertion, the first tick is CLK_HZ cycles later in run mode.
- mode is assumed synchronous to clk. The block does no mode debouncing.

## Configuration
- WATCH_TK_BCD_EN defined: secs, mins and hours are packed BCD, {tens[3:0], ones[3:0]}. Example: 59 -> 8'h59, 12 h hour 12 -> 8'h12.
- WATCH_TK_BCD_EN undefined: outputs are plain binary, zero-extended to 8 bits (59 -> 8'd59).
- Internal counters are binary in both builds. Only the output decode changes.

## Test plan
- CLK_HZ=10, reset, run mode -> secs=0 at reset; tick_1hz every 10 cycles; secs=1 after the first tick.
- Preset 23:59:59 via set modes, return to 00, wait 10 cycles -> 00:00:00, pm=0, single tick_1hz.
- mode=10, min=0, minus_pulse -> mins=59, hours unchanged; plus_pulse and minus_pulse together -> no change.
- mode=01 entry with secs=37 -> secs=0 next cycle; plus_pulse in the entry cycle ignored.
- hr_r=0, fmt_toggle -> fmt24=0, hours=12, pm=0; hr_r=13 -> hours=1, pm=1; toggle again -> hours=13.
- Reset asserted mid-count at prescaler=6 -> all outputs at reset values next cycle; next tick 10 cycles after deassertion. With WATCH_TK_BCD_EN, 45 s reads 8'h45.
